// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and nibble width for the serial adder
package adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  localparam int NIBBLE = 4;
endpackage

// File: rtl/rca_4bit.sv
// rca_4bit: 4-bit ripple adder; a, b, carry_start in -> sum, carry out
module rca_4bit
  import adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              carry_start,
  output logic [NIBBLE-1:0] sum,
  output logic              carry
);
  assign {carry, sum} = (NIBBLE+1)'(a) + (NIBBLE+1)'(b) + (NIBBLE+1)'(carry_start);
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add one nibble per clock via rca_4bit; in: in_valid/a/b/c_in, out_ready; out: in_ready, out_valid/sum/c_out/zero
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             zero
);
  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic              carry_q, carry_d, rca_c;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NIBBLE-1:0] rca_s;
  rca_4bit u_rca (
    .a(a_q[NIBBLE-1:0]),
    .b(b_q[NIBBLE-1:0]),
    .carry_start(carry_q),
    .sum(rca_s),
    .carry(rca_c)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE && in_valid) begin
      state_d = ST_RUN;
      a_d     = a;
      b_d     = b;
      carry_d = c_in;
      cnt_d   = '0;
    end
    if (state_q == ST_RUN) begin
      a_d     = a_q >> NIBBLE;
      b_d     = b_q >> NIBBLE;
      res_d   = (res_q >> NIBBLE) | (WIDTH'(rca_s) << (WIDTH - NIBBLE));
      carry_d = rca_c;
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == CW'(N - 1) ? ST_DONE : ST_RUN;
    end
    if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign sum       = res_q;
  assign c_out     = carry_q;
  assign zero      = out_valid && res_q == '0;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for nibble_serial_adder (WIDTH 16 and 8)
module tb_nibble_serial_adder;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, c_in = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        in_ready, out_valid, c_out, zero;
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1, c_in8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        in_ready8, out_valid8, c_out8, zero8;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic [15:0] s;
    logic        c;
    int          acc;
    int          stall;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_out(c_out), .zero(zero)
  );
  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8), .c_in(c_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .c_out(c_out8), .zero(zero8)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input int st);
    int n = 0;
    logic [16:0] r;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      return;
    end
    a = ta;
    b = tb;
    c_in = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    r = {1'b0, ta} + {1'b0, tb} + 17'(tc);
    q.push_back('{r[15:0], r[16], cyc, st});
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) continue;
    if (!out_valid) begin
      if (q.size() > 0) out_ready = q[0].stall == 0;
    end else if (q.size() == 0) begin
      chk("unexpected_out_valid", out_valid, 0);
      out_ready = 1'b1;
    end else begin
      mon_e = q.pop_front();
      chk("latency", cyc - mon_e.acc, 4);
      chk("sum", sum, mon_e.s);
      chk("c_out", c_out, mon_e.c);
      chk("zero", zero, mon_e.s == 16'h0);
      for (int i = 0; i < mon_e.stall; i++) begin
        in_valid = 1'b1;
        a = 16'hAAAA;
        b = 16'hAAAA;
        @(negedge clk);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_sum", sum, mon_e.s);
        chk("bp_c_out", c_out, mon_e.c);
        chk("bp_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ret_in_ready", in_ready, 1);
      chk("ret_out_valid", out_valid, 0);
    end
  end
  initial begin
    int n, acc;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready8", in_ready8, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h1234, 16'h4321, 1'b0, 0);
    issue(16'hFFFF, 16'h0001, 1'b0, 0);
    issue(16'h0FFF, 16'h0000, 1'b1, 0);
    issue(16'h1234, 16'h4321, 1'b0, 5);
    issue(16'h1234, 16'h4321, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_sum_nonzero", sum != 16'h0, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_c_out", c_out, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0001, 16'h0001, 1'b0, 0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 0);
    repeat (30) issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0);
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("w8_in_ready", in_ready8, 1);
    a8 = 8'hFF;
    b8 = 8'hFF;
    c_in8 = 1'b1;
    in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    acc = cyc;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w8_out_valid", out_valid8, 1);
    chk("w8_latency", cyc - acc, 2);
    chk("w8_sum", sum8, 8'hFF);
    chk("w8_c_out", c_out8, 1);
    chk("w8_zero", zero8, 0);
    @(negedge clk);
    chk("w8_ret_in_ready", in_ready8, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
